ads1292_sample_fifo: RTL and testbench

// - Elastic buffer between ads1292_filter (i_CLK domain) and sensor_core, which runs on the divide-by-2 clock.
// - Absorbs filtered 24-bit ECG samples so UART back-pressure does not stall the filter.
// - Re-times the valid/ack handshake on both sides. Full-speed i_CLK only; no CDC (w_CLOCK_HALF is derived from i_CLK).

---
 rtl/ads1292_sample_fifo.sv | 103 ++++++++++
 tb/tb_ads1292_sample_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1292_sample_fifo.sv
// Elastic sample FIFO between ads1292_filter and sensor_core with level-to-pulse handshakes.
// Define ADS1292_FIFO_OVF_CNT_EN to build the saturating dropped-sample counter.
module ads1292_sample_fifo #(
    parameter int DW         = 24,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTN,
    input  logic [DW-1:0]         i_ADS1292_FILTERED_DATA,
    input  logic                  i_ADS1292_FILTERED_DATA_VALID,
    output logic                  o_ADS1292_FILTERED_DATA_ACK,
    output logic [DW-1:0]         o_ADS1292_FIFO_DATA,
    output logic                  o_ADS1292_FIFO_DATA_VALID,
    input  logic                  i_ADS1292_FIFO_DATA_ACK,
    output logic [DEPTH_LOG2:0]   o_ADS1292_FIFO_LEVEL,
    input  logic                  i_OVF_CLR,
    output logic [7:0]            o_OVF_CNT
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT_LOW} state_t;

    state_t                state, state_nxt;
    logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
    logic [DW-1:0]         mem [DEPTH];
    logic                  ack_d;
    logic                  full, empty;
    logic                  push_req, push, pop, drop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // Half-rate consumer holds ack for several cycles; only its rising edge pops.
    assign pop  = i_ADS1292_FIFO_DATA_ACK & ~ack_d & ~empty;
    // A same-cycle pop frees a slot, so a push into a full FIFO is still taken.
    assign push = push_req & (~full | pop);
    assign drop = push_req & full & ~pop;

    always_comb begin
        state_nxt                   = state;
        push_req                    = 1'b0;
        o_ADS1292_FILTERED_DATA_ACK = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_ADS1292_FILTERED_DATA_VALID) begin
                    push_req  = 1'b1;
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                o_ADS1292_FILTERED_DATA_ACK = 1'b1;
                state_nxt                   = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!i_ADS1292_FILTERED_DATA_VALID) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ack_d  <= 1'b0;
        end else begin
            state <= state_nxt;
            ack_d <= i_ADS1292_FIFO_DATA_ACK;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= i_ADS1292_FILTERED_DATA;
    end

    // Storage is not reset, so mask the head while empty to keep the output clean.
    assign o_ADS1292_FIFO_DATA       = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign o_ADS1292_FIFO_DATA_VALID = ~empty;
    assign o_ADS1292_FIFO_LEVEL      = wr_ptr - rd_ptr;

`ifdef ADS1292_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt;

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN)                       ovf_cnt <= 8'h00;
        else if (i_OVF_CLR)                ovf_cnt <= 8'h00;
        else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'h01;
    end

    assign o_OVF_CNT = ovf_cnt;
`else
    logic unused_ovf;
    assign unused_ovf = &{1'b0, i_OVF_CLR, drop};
    assign o_OVF_CNT  = 8'h00;
`endif

endmodule

// File: tb/tb_ads1292_sample_fifo.sv
// Bench for ads1292_sample_fifo: table vectors, corner sequences and a queue-based random model.
module tb_ads1292_sample_fifo;

`ifdef ADS1292_FIFO_OVF_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ack;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ack;
    logic [3:0]  level;
    logic        ovf_clr;
    logic [7:0]  ovf_cnt;

    ads1292_sample_fifo #(.DW(24), .DEPTH_LOG2(3)) dut (
        .i_CLK                         (clk),
        .i_RSTN                        (rst_n),
        .i_ADS1292_FILTERED_DATA       (in_data),
        .i_ADS1292_FILTERED_DATA_VALID (in_valid),
        .o_ADS1292_FILTERED_DATA_ACK   (in_ack),
        .o_ADS1292_FIFO_DATA           (out_data),
        .o_ADS1292_FIFO_DATA_VALID     (out_valid),
        .i_ADS1292_FIFO_DATA_ACK       (out_ack),
        .o_ADS1292_FIFO_LEVEL          (level),
        .i_OVF_CLR                     (ovf_clr),
        .o_OVF_CNT                     (ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an ordinary queue plus a drop counter.
    int unsigned mq[$];
    int          movf;

    typedef struct {
        bit          is_push;
        logic [23:0] data;
        int          arg;
        logic [3:0]  exp_level;
        bit          exp_valid;
        logic [23:0] exp_head;
    } vec_t;
    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ack  = 1'b0;
        ovf_clr  = 1'b0;
        rst_n    = 1'b0;
        #3;
        rst_n = 1'b1;
        mq.delete();
        movf = 0;
        tick();
    endtask

    task automatic model_push(input logic [23:0] d);
        if (mq.size() < DEPTH) mq.push_back(d);
        else if (OVF_EN && movf < 255) movf++;
    endtask

    // Full upstream handshake: raise valid, expect one ack, hold, then release.
    task automatic push_sample(input logic [23:0] d, input int hold, output int acks);
        acks     = 0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 4 && acks == 0; i++) begin
            tick();
            if (in_ack) acks++;
        end
        if (acks == 0) check("ack_timeout", 0, 1);
        repeat (hold) begin
            tick();
            if (in_ack) acks++;
        end
        in_valid = 1'b0;
        repeat (2) begin
            tick();
            if (in_ack) acks++;
        end
        check("ack_count", acks, 1);
        if (acks > 0) model_push(d);
    endtask

    task automatic pop_word(input int len);
        out_ack = 1'b1;
        repeat (len) tick();
        out_ack = 1'b0;
        tick();
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic check_model(input string tag);
        check({tag, "_level"}, level, mq.size());
        check({tag, "_valid"}, out_valid, mq.size() != 0);
        if (mq.size() > 0) check({tag, "_head"}, out_data, mq[0]);
        check({tag, "_ovf"}, ovf_cnt, movf);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acks, total;

        tbl[0] = '{1'b1, 24'hABCDEF, 10, 4'd1, 1'b1, 24'hABCDEF};
        tbl[1] = '{1'b0, 24'h0, 2, 4'd0, 1'b0, 24'h0};
        for (int i = 0; i < 8; i++)
            tbl[2+i] = '{1'b1, 24'(i + 1), 1, 4'(i + 1), 1'b1, 24'h1};
        for (int k = 1; k <= 8; k++)
            tbl[9+k] = '{1'b0, 24'h0, 2, 4'(8 - k), k < 8, 24'(k + 1)};

        in_data  = '0;
        in_valid = 1'b0;
        out_ack  = 1'b0;
        ovf_clr  = 1'b0;
        rst_n    = 1'b0;
        #12;
        check("rst_ack", in_ack, 0);
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_ovf", ovf_cnt, 0);
        do_reset();

        // Table: single held sample, then 8 pushes drained by 2-cycle acks.
        for (int v = 0; v < 18; v++) begin
            if (tbl[v].is_push) push_sample(tbl[v].data, tbl[v].arg, acks);
            else pop_word(tbl[v].arg);
            check($sformatf("tbl%0d_level", v), level, tbl[v].exp_level);
            check($sformatf("tbl%0d_valid", v), out_valid, tbl[v].exp_valid);
            if (tbl[v].exp_valid) check($sformatf("tbl%0d_head", v), out_data, tbl[v].exp_head);
        end

        // Overflow: 10 pushes into 8 slots, newest dropped but still acked.
        do_reset();
        total = 0;
        for (int i = 1; i <= 10; i++) begin
            push_sample(24'(i), 1, acks);
            total += acks;
        end
        check("ovf_acks", total, 10);
        check("ovf_level", level, 8);
        check("ovf_head", out_data, 24'h1);
        check("ovf_cnt", ovf_cnt, OVF_EN ? 2 : 0);

        // Pop rising edge coincides with a push while full.
        in_data  = 24'h000009;
        in_valid = 1'b1;
        out_ack  = 1'b1;
        tick();
        check("simul_ack", in_ack, 1);
        check("simul_level", level, 8);
        check("simul_head", out_data, 24'h2);
        tick();
        out_ack  = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check("simul_level2", level, 8);
        check("simul_ovf", ovf_cnt, OVF_EN ? 2 : 0);
        for (int i = 2; i <= 8; i++) begin
            check($sformatf("simul_drain%0d", i), out_data, 24'(i));
            pop_word(2);
        end
        check("simul_tail", out_data, 24'h9);
        check("simul_tail_level", level, 1);

        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf_cnt, 0);

        // Ack held high while empty must not pop a later sample.
        do_reset();
        out_ack = 1'b1;
        repeat (3) tick();
        check("emptyack_level", level, 0);
        check("emptyack_valid", out_valid, 0);
        push_sample(24'h123456, 2, acks);
        check("emptyack_push_level", level, 1);
        check("emptyack_head", out_data, 24'h123456);
        out_ack = 1'b0;
        tick();
        check("emptyack_hold_level", level, 1);
        pop_word(2);
        check("emptyack_pop_level", level, 0);

        // Async reset while in the ack state with three words stored.
        do_reset();
        push_sample(24'h000111, 1, acks);
        push_sample(24'h000222, 1, acks);
        in_data  = 24'h000333;
        in_valid = 1'b1;
        tick();
        check("mid_ack", in_ack, 1);
        check("mid_level", level, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", in_ack, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_ovf", ovf_cnt, 0);
        tick();
        rst_n = 1'b1;
        total = 0;
        repeat (6) begin
            tick();
            if (in_ack) total++;
        end
        in_valid = 1'b0;
        repeat (2) begin
            tick();
            if (in_ack) total++;
        end
        check("mid_recapture_acks", total, 1);
        check("mid_recapture_level", level, 1);
        check("mid_recapture_head", out_data, 24'h000333);

        // Random traffic against the queue model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                push_sample(24'($urandom), $urandom_range(0, 3), acks);
            end else if (r <= 8) begin
                pop_word($urandom_range(1, 3));
            end else begin
                ovf_clr = 1'b1;
                tick();
                ovf_clr = 1'b0;
                movf = 0;
            end
            check_model($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
